// File: rtl/multi_layer_block_scheduler.sv
// multi_layer_block_scheduler: walks each configured layer through FF/BF/BB/FB two-block descriptors
module multi_layer_block_scheduler #(
  parameter int DATA_W = 32,
  parameter int NUM_LAYERS = 8,
  localparam int LAYER_W = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cfg_we_i,
  input  logic [LAYER_W-1:0] cfg_layer_i,
  input  logic [DATA_W-1:0]  cfg_fwd_len_i,
  input  logic [DATA_W-1:0]  cfg_bwd_len_i,
  input  logic [DATA_W-1:0]  cfg_fwd_bp_i,
  input  logic [DATA_W-1:0]  cfg_bwd_bp_i,
  output logic               cfg_ready_o,
  input  logic               start_i,
  input  logic [LAYER_W:0]   num_layers_i,
  input  logic               abort_i,
  output logic               blk_valid_o,
  input  logic               blk_ready_i,
  output logic [DATA_W-1:0]  block0_start_o,
  output logic [DATA_W-1:0]  block0_length_o,
  output logic [DATA_W-1:0]  block1_start_o,
  output logic [DATA_W-1:0]  block1_length_o,
  output logic [1:0]         block_type_o,
  output logic [LAYER_W-1:0] layer_idx_o,
  input  logic               block_finish_valid_i,
  output logic               busy_o,
  output logic               done_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [1:0] FF = 2'b00, FB = 2'b01, BF = 2'b10, BB = 2'b11;
  localparam logic [LAYER_W:0] NL_MAX = (LAYER_W+1)'(NUM_LAYERS);
  state_t state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [1:0] phase_q, phase_d;
  logic [LAYER_W:0] nl_q, nl_d;
  logic [DATA_W-1:0] fwd_len_q [NUM_LAYERS];
  logic [DATA_W-1:0] bwd_len_q [NUM_LAYERS];
  logic [DATA_W-1:0] fwd_bp_q [NUM_LAYERS];
  logic [DATA_W-1:0] bwd_bp_q [NUM_LAYERS];
  logic [DATA_W-1:0] fl, fb, bl, bb, fd, bd, d0s, d0l, d1s, d1l;
  logic cfg_ok, nl_ok, last;
  assign cfg_ok = {1'b0, cfg_layer_i} < NL_MAX;
  assign nl_ok = num_layers_i != '0 && num_layers_i <= NL_MAX;
  assign last = ({1'b0, layer_q} + (LAYER_W+1)'(1)) == nl_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        fwd_len_q[i] <= '0;
        bwd_len_q[i] <= '0;
        fwd_bp_q[i] <= '0;
        bwd_bp_q[i] <= '0;
      end
    end else if (cfg_we_i && cfg_ready_o && cfg_ok) begin
      fwd_len_q[cfg_layer_i] <= cfg_fwd_len_i;
      bwd_len_q[cfg_layer_i] <= cfg_bwd_len_i;
      fwd_bp_q[cfg_layer_i] <= cfg_fwd_bp_i > cfg_fwd_len_i ? cfg_fwd_len_i : cfg_fwd_bp_i;
      bwd_bp_q[cfg_layer_i] <= cfg_bwd_bp_i > cfg_bwd_len_i ? cfg_bwd_len_i : cfg_bwd_bp_i;
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      layer_q <= '0;
      phase_q <= FF;
      nl_q <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      phase_q <= phase_d;
      nl_q <= nl_d;
    end
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    phase_d = phase_q;
    nl_d = nl_q;
    case (state_q)
      IDLE: if (start_i) begin
        nl_d = num_layers_i;
        layer_d = '0;
        phase_d = FF;
        state_d = nl_ok ? ISSUE : DONE;
      end
      ISSUE: if (blk_ready_i) state_d = WAIT;
      WAIT: if (block_finish_valid_i) begin
        // gray-style rotation 00->10->11->01->00 is exactly FF->BF->BB->FB->FF
        phase_d = {~phase_q[0], phase_q[1]};
        state_d = phase_q == FB && last ? DONE : ISSUE;
        layer_d = phase_q != FB ? layer_q : last ? '0 : layer_q + LAYER_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d = IDLE;
      layer_d = '0;
      phase_d = FF;
    end
  end
  always_comb begin
    cfg_ready_o = state_q == IDLE;
    blk_valid_o = state_q == ISSUE;
    busy_o = state_q != IDLE;
    done_o = state_q == DONE;
  end
  always_comb begin
    fl = fwd_len_q[layer_d];
    fb = fwd_bp_q[layer_d];
    bl = bwd_len_q[layer_d];
    bb = bwd_bp_q[layer_d];
    fd = fl - fb;
    bd = bl - bb;
    d0s = phase_d == FF ? fb : phase_d == BB ? bb : '0;
    d0l = phase_d == FF ? fd : phase_d == BF ? bb : phase_d == BB ? bd : fb;
    d1s = phase_d == BF ? fd : phase_d == FB ? bd : '0;
    d1l = phase_d == FF ? fd : phase_d == BF ? fb : phase_d == BB ? bd : bb;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      block0_start_o <= '0;
      block0_length_o <= '0;
      block1_start_o <= '0;
      block1_length_o <= '0;
      block_type_o <= '0;
      layer_idx_o <= '0;
    end else begin
      block0_start_o <= state_d == ISSUE ? d0s : '0;
      block0_length_o <= state_d == ISSUE ? d0l : '0;
      block1_start_o <= state_d == ISSUE ? d1s : '0;
      block1_length_o <= state_d == ISSUE ? d1l : '0;
      block_type_o <= state_d == ISSUE ? phase_d : '0;
      layer_idx_o <= state_d == ISSUE ? layer_d : '0;
    end
endmodule

// File: tb/tb_multi_layer_block_scheduler.sv
// tb_multi_layer_block_scheduler: scoreboard bench with directed descriptor vectors
module tb_multi_layer_block_scheduler;
  localparam int DW = 32, NL = 6, LW = 3;
  localparam logic [1:0] FF = 2'b00, FB = 2'b01, BF = 2'b10, BB = 2'b11;
  typedef struct packed {
    logic [DW-1:0] s0, l0, s1, l1;
    logic [1:0] t;
    logic [LW-1:0] ly;
  } desc_t;
  logic clk = 0, rst_ni = 0;
  logic cfg_we_i = 0, start_i = 0, abort_i = 0, blk_ready_i = 0, block_finish_valid_i = 0;
  logic [LW-1:0] cfg_layer_i = '0;
  logic [DW-1:0] cfg_fwd_len_i = '0, cfg_bwd_len_i = '0, cfg_fwd_bp_i = '0, cfg_bwd_bp_i = '0;
  logic [LW:0] num_layers_i = '0;
  logic cfg_ready_o, blk_valid_o, busy_o, done_o;
  logic [DW-1:0] block0_start_o, block0_length_o, block1_start_o, block1_length_o;
  logic [1:0] block_type_o;
  logic [LW-1:0] layer_idx_o;
  desc_t exp_q [$];
  desc_t got, want;
  int checks = 0, errors = 0, done_cnt = 0, d;
  multi_layer_block_scheduler #(.DATA_W(DW), .NUM_LAYERS(NL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_layer_i(cfg_layer_i),
    .cfg_fwd_len_i(cfg_fwd_len_i), .cfg_bwd_len_i(cfg_bwd_len_i),
    .cfg_fwd_bp_i(cfg_fwd_bp_i), .cfg_bwd_bp_i(cfg_bwd_bp_i), .cfg_ready_o(cfg_ready_o),
    .start_i(start_i), .num_layers_i(num_layers_i), .abort_i(abort_i),
    .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i),
    .block0_start_o(block0_start_o), .block0_length_o(block0_length_o),
    .block1_start_o(block1_start_o), .block1_length_o(block1_length_o),
    .block_type_o(block_type_o), .layer_idx_o(layer_idx_o),
    .block_finish_valid_i(block_finish_valid_i), .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_ni && blk_valid_o && blk_ready_i) begin
      got = {block0_start_o, block0_length_o, block1_start_o, block1_length_o, block_type_o, layer_idx_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL desc_unexpected act=%h req=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL desc act=%h req=%h", got, want);
        end
      end
    end
    if (done_o) done_cnt++;
  end
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(int s0, int l0, int s1, int l1, logic [1:0] t, int ly);
    exp_q.push_back({DW'(s0), DW'(l0), DW'(s1), DW'(l1), t, LW'(ly)});
  endtask
  task automatic push_l0();
    push(30, 70, 0, 70, FF, 0);
    push(0, 20, 70, 30, BF, 0);
    push(20, 60, 0, 60, BB, 0);
    push(0, 30, 60, 20, FB, 0);
  endtask
  task automatic wr(int ly, int fl, int fb, int bl, int bb);
    cfg_we_i = 1;
    cfg_layer_i = LW'(ly);
    cfg_fwd_len_i = DW'(fl);
    cfg_fwd_bp_i = DW'(fb);
    cfg_bwd_len_i = DW'(bl);
    cfg_bwd_bp_i = DW'(bb);
    step();
    cfg_we_i = 0;
  endtask
  task automatic start(int n);
    start_i = 1;
    num_layers_i = (LW+1)'(n);
    step();
    start_i = 0;
  endtask
  task automatic wait_valid();
    for (int k = 0; k < 50 && !blk_valid_o; k++) step();
    chk("valid_timeout", blk_valid_o, 1);
  endtask
  task automatic serve(int n);
    for (int i = 0; i < n; i++) begin
      wait_valid();
      blk_ready_i = 1;
      step();
      step();
      block_finish_valid_i = 1;
      step();
      block_finish_valid_i = 0;
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_cfg_ready", cfg_ready_o, 1);
    chk("rst_valid", blk_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_desc", {block0_start_o, block0_length_o}, 0);
    rst_ni = 1;
    step();
    wr(0, 100, 30, 80, 20);
    push_l0();
    d = done_cnt;
    blk_ready_i = 1;
    start(1);
    chk("busy_run", busy_o, 1);
    serve(4);
    step();
    step();
    chk("done_once_l1", done_cnt - d, 1);
    chk("idle_after", busy_o, 0);
    blk_ready_i = 0;
    push_l0();
    start(1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      block_finish_valid_i = i == 1;
      step();
      chk("hold_valid", blk_valid_o, 1);
      chk("hold_b0", {block0_start_o, block0_length_o}, {32'd30, 32'd70});
      chk("hold_b1", {block1_start_o, block1_length_o}, {32'd0, 32'd70});
    end
    block_finish_valid_i = 0;
    serve(4);
    step();
    step();
    wr(0, 100, 150, 80, 20);
    push(100, 0, 0, 0, FF, 0);
    push(0, 20, 0, 100, BF, 0);
    push(20, 60, 0, 60, BB, 0);
    push(0, 100, 60, 20, FB, 0);
    start(1);
    serve(4);
    step();
    step();
    wr(0, 100, 30, 80, 20);
    wr(1, 40, 10, 50, 60);
    wr(2, 7, 7, 9, 0);
    push_l0();
    push(10, 30, 0, 30, FF, 1);
    push(0, 50, 30, 10, BF, 1);
    push(50, 0, 0, 0, BB, 1);
    push(0, 10, 0, 50, FB, 1);
    push(7, 0, 0, 0, FF, 2);
    push(0, 0, 0, 7, BF, 2);
    push(0, 9, 0, 9, BB, 2);
    push(0, 7, 9, 0, FB, 2);
    d = done_cnt;
    start(3);
    serve(12);
    step();
    step();
    chk("done_once_l3", done_cnt - d, 1);
    d = done_cnt;
    push_l0();
    push(10, 30, 0, 30, FF, 1);
    start(3);
    serve(4);
    wait_valid();
    step();
    abort_i = 1;
    step();
    abort_i = 0;
    chk("abort_busy", busy_o, 0);
    chk("abort_valid", blk_valid_o, 0);
    for (int i = 0; i < 5; i++) step();
    chk("abort_no_done", done_cnt - d, 0);
    push_l0();
    start(1);
    serve(4);
    step();
    step();
    blk_ready_i = 0;
    push_l0();
    start(1);
    wait_valid();
    chk("busy_cfg_ready", cfg_ready_o, 0);
    wr(0, 1, 1, 1, 1);
    serve(4);
    step();
    step();
    wr(6, 5, 5, 5, 5);
    push_l0();
    start(1);
    serve(4);
    step();
    step();
    d = done_cnt;
    start(0);
    chk("nl0_done", done_o, 1);
    step();
    chk("nl0_done_off", done_o, 0);
    start(7);
    chk("nl7_done", done_o, 1);
    chk("nl7_valid", blk_valid_o, 0);
    step();
    chk("nl_bad_done_cnt", done_cnt - d, 2);
    blk_ready_i = 0;
    start(1);
    wait_valid();
    rst_ni = 0;
    #1;
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_valid", blk_valid_o, 0);
    step();
    rst_ni = 1;
    step();
    push(0, 0, 0, 0, FF, 0);
    push(0, 0, 0, 0, BF, 0);
    push(0, 0, 0, 0, BB, 0);
    push(0, 0, 0, 0, FB, 0);
    start(1);
    serve(4);
    step();
    step();
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
